// File: rtl/plot_point_feeder.sv
// Buffers (x, y) plot points in a small FIFO and presents one at a time as
// the display dot offset. The dot changes only on a vsync-derived frame tick.
//
// Ports:
//   CLOCK_50, reset    : system clock, async active-high reset
//   s_valid/s_ready    : upstream coordinate handshake
//   s_x, s_y           : coordinate payload
//   vga_vs             : display vsync (asynchronous, synchronized here)
//   dot_x, dot_y       : displayed dot offset (registered)
//   dot_valid          : a point has been loaded since reset
//   fill               : FIFO occupancy
//   drop_count         : saturating count of rejected samples
//
// Build option: define PLOT_CLAMP_EN to clamp out-of-range samples into
// the plot area instead of dropping them.

module plot_point_feeder #(
  parameter int MAX_X       = 580,
  parameter int MAX_Y       = 218,
  parameter int DEPTH       = 8,
  parameter int HOLD_FRAMES = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [9:0]               s_x,
  input  logic [8:0]               s_y,
  input  logic                     vga_vs,
  output logic [9:0]               dot_x,
  output logic [8:0]               dot_y,
  output logic                     dot_valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [FW-1:0] FULL      = FW'(DEPTH);
  localparam logic [9:0]    LIM_X     = 10'(MAX_X);
  localparam logic [8:0]    LIM_Y     = 9'(MAX_Y);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic {
    WAIT_FIRST,
    SHOW
  } state_t;

  state_t state;

  logic [9:0]    mem_x [DEPTH];
  logic [8:0]    mem_y [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    hold_cnt;

  logic vs_s0;
  logic vs_s1;
  logic vs_s2;
  logic frame_tick;

  logic accept;
  logic push;
  logic pop;
  logic hold_done;
  logic [9:0] wr_x;
  logic [8:0] wr_y;

  // Two flops for metastability, third for rising-edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vs_s0 <= 1'b0;
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
    end else begin
      vs_s0 <= vga_vs;
      vs_s1 <= vs_s0;
      vs_s2 <= vs_s1;
    end
  end

  assign frame_tick = vs_s1 & ~vs_s2;

  // Readiness comes from registered fill only, so a pop on this edge
  // cannot open a slot for a push on the same edge.
  assign s_ready = (fill != FULL);
  assign accept  = s_valid & s_ready;

`ifdef PLOT_CLAMP_EN
  assign push       = accept;
  assign wr_x       = (s_x > LIM_X) ? LIM_X : s_x;
  assign wr_y       = (s_y > LIM_Y) ? LIM_Y : s_y;
  assign drop_count = 8'd0;
`else
  logic legal;

  assign legal = (s_x <= LIM_X) && (s_y <= LIM_Y);
  assign push  = accept & legal;
  assign wr_x  = s_x;
  assign wr_y  = s_y;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (accept && !legal && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

  assign hold_done = (hold_cnt == HOLD_LAST);

  // Pop eligibility looks at pre-edge fill; a push into an empty FIFO
  // therefore never feeds the same edge's pop.
  always_comb begin
    pop = 1'b0;
    if (frame_tick && fill != '0) begin
      case (state)
        WAIT_FIRST: pop = 1'b1;
        SHOW:       pop = hold_done;
      endcase
    end
  end

  // Storage has no reset; validity is carried by fill and the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_x[wr_ptr] <= wr_x;
      mem_y[wr_ptr] <= wr_y;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      state     <= WAIT_FIRST;
      dot_x     <= 10'd0;
      dot_y     <= 9'd0;
      dot_valid <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase

      case (state)
        WAIT_FIRST: begin
          if (pop) begin
            dot_x     <= mem_x[rd_ptr];
            dot_y     <= mem_y[rd_ptr];
            dot_valid <= 1'b1;
            hold_cnt  <= 8'd0;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (frame_tick) begin
            if (!hold_done) begin
              hold_cnt <= hold_cnt + 8'd1;
            end else if (pop) begin
              dot_x    <= mem_x[rd_ptr];
              dot_y    <= mem_y[rd_ptr];
              hold_cnt <= 8'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plot_point_feeder.sv
// Randomized scoreboard bench for plot_point_feeder with a frame-level
// queue model of the feeder.

module tb_plot_point_feeder;

  localparam int DEPTH = 8;
  localparam int HOLD  = 3;
  localparam int MAX_X = 580;
  localparam int MAX_Y = 218;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       s_valid = 1'b0;
  logic       vga_vs  = 1'b0;
  logic [9:0] s_x     = '0;
  logic [8:0] s_y     = '0;
  logic       s_ready;
  logic [9:0] dot_x;
  logic [8:0] dot_y;
  logic       dot_valid;
  logic [3:0] fill;
  logic [7:0] drop_count;

  always #10 clk = ~clk;

  plot_point_feeder #(
    .MAX_X(MAX_X),
    .MAX_Y(MAX_Y),
    .DEPTH(DEPTH),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_x(s_x),
    .s_y(s_y),
    .vga_vs(vga_vs),
    .dot_x(dot_x),
    .dot_y(dot_y),
    .dot_valid(dot_valid),
    .fill(fill),
    .drop_count(drop_count)
  );

  typedef struct {
    int x;
    int y;
  } pt_t;

  typedef struct {
    int x;
    int y;
    int v;
    int f;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;

  pt_t  mq[$];
  exp_t eq[$];
  int   m_x, m_y, m_frames, m_drop, tick_in, vs_age;
  bit   m_valid, stall;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    eq.delete();
    m_x      = 0;
    m_y      = 0;
    m_valid  = 0;
    m_frames = 0;
    m_drop   = 0;
    tick_in  = 0;
    stall    = 0;
    vs_age   = 10;
  endfunction

  // Effect of the coming rising edge, from the pre-edge inputs.
  task automatic model_edge();
    pt_t p;
    bit  acc;
    bit  tick;
    acc  = s_valid && (mq.size() < DEPTH);
    tick = 0;
    if (tick_in > 0) begin
      tick_in--;
      tick = (tick_in == 0);
    end
    if (tick) begin
      if (!m_valid || m_frames >= HOLD) begin
        if (mq.size() > 0) begin
          p        = mq.pop_front();
          m_x      = p.x;
          m_y      = p.y;
          m_valid  = 1;
          m_frames = 1;
        end
      end else begin
        m_frames++;
      end
    end
    stall = s_valid && !acc;
    if (acc) begin
`ifdef PLOT_CLAMP_EN
      p.x = (int'(s_x) > MAX_X) ? MAX_X : int'(s_x);
      p.y = (int'(s_y) > MAX_Y) ? MAX_Y : int'(s_y);
      mq.push_back(p);
`else
      if (int'(s_x) <= MAX_X && int'(s_y) <= MAX_Y) begin
        p.x = int'(s_x);
        p.y = int'(s_y);
        mq.push_back(p);
      end else if (m_drop < 255) begin
        m_drop++;
      end
`endif
    end
    if (tick) begin
      eq.push_back('{m_x, m_y, int'(m_valid), mq.size()});
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input bit v, input int x, input int y,
                             input bit vs_req);
    bit vs;
    if (vga_vs) vs = (vs_age < 4);
    else        vs = vs_req && (vs_age >= 6);
    if (vs != vga_vs) begin
      vs_age = 1;
      if (vs) tick_in = 3;
    end else begin
      vs_age++;
    end
    vga_vs  = vs;
    s_valid = v;
    s_x     = 10'(x);
    s_y     = 9'(y);
    chk("s_ready", int'(s_ready), int'(mq.size() < DEPTH));
    model_edge();
    @(negedge clk);
    chk("fill", int'(fill), mq.size());
    chk("drop_count", int'(drop_count), m_drop);
  endtask

  task automatic vsync_idle();
    int guard;
    guard = 0;
    while (!vga_vs && guard < 20) begin
      drive_cycle(0, 0, 0, 1);
      guard++;
    end
    for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    s_valid = 0;
    vga_vs  = 0;
    reset   = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Scoreboard monitor: each vsync rise yields a dot update 3 edges later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vga_vs);
      repeat (3) @(posedge clk);
      #1;
      if (eq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: dot update with no expectation (t=%0t)",
                 $time);
      end else begin
        e = eq.pop_front();
        chk("dot_x", int'(dot_x), e.x);
        chk("dot_y", int'(dot_y), e.y);
        chk("dot_valid", int'(dot_valid), e.v);
        chk("frame_fill", int'(fill), e.f);
      end
    end
  end

  initial begin : stim
    int x, y, pct;
    bit v;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_fill", int'(fill), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_dot_valid", int'(dot_valid), 0);
    chk("rst_dot_x", int'(dot_x), 0);
    chk("rst_drop", int'(drop_count), 0);
    reset = 0;

    drive_cycle(1, 100, 50, 0);
    vsync_idle();
    chk("first_dot_x", int'(dot_x), 100);
    chk("first_dot_y", int'(dot_y), 50);
    chk("first_dot_valid", int'(dot_valid), 1);
    chk("first_fill", int'(fill), 0);

    for (int i = 0; i < 9; i++) drive_cycle(1, i * 10 + 5, i + 1, 0);
    chk("full_fill", int'(fill), 8);
    chk("full_s_ready", int'(s_ready), 0);
    s_valid = 0;
    for (int i = 0; i < 3; i++) vsync_idle();
    chk("pop_fill", int'(fill), 7);
    chk("pop_s_ready", int'(s_ready), 1);
    chk("pop_dot_x", int'(dot_x), 5);
    chk("pop_dot_y", int'(dot_y), 1);

    drive_cycle(1, 600, 250, 0);
    drive_cycle(0, 0, 0, 0);

    for (int seg = 0; seg < 8; seg++) begin
      pct = (seg % 2 == 0) ? 60 : 3;
      for (int c = 0; c < 400; c++) begin
        if (stall) begin
          v = 1;
          x = int'(s_x);
          y = int'(s_y);
        end else begin
          v = ($urandom_range(0, 99) < pct);
          x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023)
                                          : $urandom_range(0, MAX_X);
          y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511)
                                          : $urandom_range(0, MAX_Y);
        end
        drive_cycle(v, x, y, $urandom_range(0, 15) == 0);
      end
    end
    for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 0);

    do_reset();
    drive_cycle(1, 7, 7, 0);
    vsync_idle();
    for (int i = 0; i < 5; i++) drive_cycle(1, 20 + i, 30 + i, 0);
    s_valid = 0;
    chk("pre_rst_fill", int'(fill), 5);
    chk("pre_rst_dot_valid", int'(dot_valid), 1);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst_fill", int'(fill), 0);
    chk("arst_dot_valid", int'(dot_valid), 0);
    chk("arst_dot_x", int'(dot_x), 0);
    chk("arst_dot_y", int'(dot_y), 0);
    chk("arst_s_ready", int'(s_ready), 1);
    chk("arst_drop", int'(drop_count), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    vsync_idle();
    chk("post_rst_dot_valid", int'(dot_valid), 0);

    repeat (5) @(negedge clk);
    n_vec++;
    if (eq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
